// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor.
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - btb_entry_t: one BTB read-port view {valid, tag, target, ctr}
//   - default BTB geometry (IDX_W, TAG_W)
//   - sat_update(): saturating counter step toward the resolved direction
package bp_pkg;

  localparam int DEF_IDX_W   = 6;
  localparam int DEF_TAG_W   = 24;
  // The entry view carries the widest tag any legal geometry can need
  // (32 - 2 byte-offset bits); narrower tags are zero-extended.
  localparam int BTB_TAG_MAX = 30;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [31:0]            target;
    logic [1:0]             ctr;
  } btb_entry_t;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage.
//   CLK, RESET         clock, async active-low reset (clears valid bits only)
//   rd_idx/rd_entry    combinational read port for the fetch lookup
//   chk_idx/chk_entry  combinational read port for resolution-time training
//   wr_*               synchronous write port (valid bit + tag/target/ctr)
// Reads never see a same-cycle write; the write lands at the clock edge.
module btb_table
  import bp_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic [IDX_W-1:0] chk_idx,
  output btb_entry_t       chk_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  logic [1:0]       wr_ctr
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
    end
  end

  // Payload arrays are qualified by valid_q, so they need no reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid_q[rd_idx];
    rd_entry.tag    = BTB_TAG_MAX'(tag_q[rd_idx]);
    rd_entry.target = target_q[rd_idx];
    rd_entry.ctr    = ctr_q[rd_idx];

    chk_entry        = '0;
    chk_entry.valid  = valid_q[chk_idx];
    chk_entry.tag    = BTB_TAG_MAX'(tag_q[chk_idx]);
    chk_entry.target = target_q[chk_idx];
    chk_entry.ctr    = ctr_q[chk_idx];
  end

endmodule

// File: rtl/branch_predictor_unit.sv
// Branch predictor sitting between IF and ID.
//   CLK, RESET                      clock, async active-low reset
//   FetchPC, FetchAdvance           fetch address and IF-latch strobe
//   PredTaken, PredTarget           same-cycle prediction back to IF
//   ID_PC, ID_Valid, is_branch,
//   is_taken, alt_address, is_link  resolution from the decode stage
//   Mispredict, CorrectPC           registered one-cycle redirect
//   BranchCount, MispredictCount,
//   LinkCount                       wrapping statistics counters
module branch_predictor_unit
  import bp_pkg::*;
#(
  parameter int         IDX_W    = DEF_IDX_W,
  parameter int         TAG_W    = DEF_TAG_W,
  parameter logic [1:0] CTR_INIT = WT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] FetchPC,
  input  logic        FetchAdvance,
  output logic        PredTaken,
  output logic [31:0] PredTarget,
  input  logic [31:0] ID_PC,
  input  logic        ID_Valid,
  input  logic        is_branch,
  input  logic        is_taken,
  input  logic [31:0] alt_address,
  input  logic        is_link,
  output logic        Mispredict,
  output logic [31:0] CorrectPC,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount,
  output logic [31:0] LinkCount
);

  logic [IDX_W-1:0] f_idx, r_idx;
  logic [TAG_W-1:0] f_tag, r_tag;
  btb_entry_t       f_ent, r_ent;
  logic             f_hit, r_hit;

  logic             wr_en, wr_valid;
  logic [31:0]      wr_target;
  logic [1:0]       wr_ctr;

  logic             pv_q, pt_q;
  logic [31:0]      ppc_q, ptgt_q;

  logic             used, ptaken, mis;
  logic [31:0]      corr_pc;

  assign f_idx = FetchPC[IDX_W+1:2];
  assign f_tag = FetchPC[IDX_W+TAG_W+1:IDX_W+2];
  assign r_idx = ID_PC[IDX_W+1:2];
  assign r_tag = ID_PC[IDX_W+TAG_W+1:IDX_W+2];

  btb_table #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
    .CLK       (CLK),
    .RESET     (RESET),
    .rd_idx    (f_idx),
    .rd_entry  (f_ent),
    .chk_idx   (r_idx),
    .chk_entry (r_ent),
    .wr_en     (wr_en),
    .wr_idx    (r_idx),
    .wr_valid  (wr_valid),
    .wr_tag    (r_tag),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  assign f_hit = f_ent.valid && (f_ent.tag == BTB_TAG_MAX'(f_tag));
  assign r_hit = r_ent.valid && (r_ent.tag == BTB_TAG_MAX'(r_tag));

  assign PredTaken  = f_hit && (f_ent.ctr >= WT);
  assign PredTarget = f_hit ? f_ent.target : FetchPC + 32'd4;

  // A prediction only counts if the instruction now in ID is the one it was
  // made for; otherwise ID is judged against an implicit not-taken guess.
  always_comb begin
    used   = pv_q && (ppc_q == ID_PC);
    ptaken = used && pt_q;
    if (is_branch)
      mis = (ptaken != is_taken) || (is_taken && (ptgt_q != alt_address));
    else
      mis = ptaken;
    if (!is_branch)    corr_pc = ID_PC + 32'd4;
    else if (is_taken) corr_pc = alt_address;
    else               corr_pc = ID_PC + 32'd8;  // fall-through skips the delay slot
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = 1'b1;
    wr_target = alt_address;
    wr_ctr    = CTR_INIT;
    if (ID_Valid) begin
      if (is_branch && r_hit) begin
        wr_en     = 1'b1;
        wr_ctr    = sat_update(r_ent.ctr, is_taken);
        wr_target = is_taken ? alt_address : r_ent.target;
      end else if (is_branch && is_taken) begin
        wr_en = 1'b1;
      end else if (!is_branch && r_hit) begin
        // Non-branch aliasing onto a BTB entry: drop the stale entry.
        wr_en     = 1'b1;
        wr_valid  = 1'b0;
        wr_target = r_ent.target;
        wr_ctr    = r_ent.ctr;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pv_q   <= 1'b0;
      ppc_q  <= '0;
      pt_q   <= 1'b0;
      ptgt_q <= '0;
    end else if (Mispredict) begin
      pv_q <= 1'b0;
    end else if (FetchAdvance) begin
      pv_q   <= 1'b1;
      ppc_q  <= FetchPC;
      pt_q   <= PredTaken;
      ptgt_q <= PredTarget;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Mispredict      <= 1'b0;
      CorrectPC       <= '0;
      BranchCount     <= '0;
      MispredictCount <= '0;
      LinkCount       <= '0;
    end else begin
      Mispredict <= ID_Valid && mis;
      if (ID_Valid) begin
        CorrectPC <= corr_pc;
        if (is_branch)            BranchCount     <= BranchCount + 32'd1;
        if (mis)                  MispredictCount <= MispredictCount + 32'd1;
        if (is_branch && is_link) LinkCount       <= LinkCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_unit.sv
module tb_branch_predictor_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] FetchPC, ID_PC, alt_address;
  logic        FetchAdvance, ID_Valid, is_branch, is_taken, is_link;
  logic        PredTaken, Mispredict;
  logic [31:0] PredTarget, CorrectPC, BranchCount, MispredictCount, LinkCount;

  branch_predictor_unit dut (
    .CLK(CLK), .RESET(RESET),
    .FetchPC(FetchPC), .FetchAdvance(FetchAdvance),
    .PredTaken(PredTaken), .PredTarget(PredTarget),
    .ID_PC(ID_PC), .ID_Valid(ID_Valid), .is_branch(is_branch),
    .is_taken(is_taken), .alt_address(alt_address), .is_link(is_link),
    .Mispredict(Mispredict), .CorrectPC(CorrectPC),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount),
    .LinkCount(LinkCount)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct { logic taken; logic [31:0] target; } pred_t;
  typedef struct { logic mis; logic [31:0] cpc, bc, mc, lc; } post_t;
  pred_t pred_q[$];
  post_t post_q[$];

  // Reference model: BTB as plain arrays, pending prediction, outputs.
  bit          m_valid[64];
  logic [23:0] m_tag[64];
  logic [31:0] m_tgt[64];
  int          m_ctr[64];
  bit          m_pv, m_pt, m_mis;
  logic [31:0] m_ppc, m_ptgt, m_cpc, m_bc, m_mc, m_lc;

  logic [31:0] pool[8] = '{32'h0040_0100, 32'h0040_0104, 32'h0040_0108, 32'h0040_0200,
                           32'h0040_0300, 32'h0040_1104, 32'h0040_010c, 32'h7ff0_0000};

  function void model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    m_pv = 0; m_pt = 0; m_mis = 0;
    m_ppc = 0; m_ptgt = 0; m_cpc = 0; m_bc = 0; m_mc = 0; m_lc = 0;
    pred_q.delete();
    post_q.delete();
  endfunction

  task automatic set_idle();
    FetchPC = 0; FetchAdvance = 0; ID_PC = 0; ID_Valid = 0;
    is_branch = 0; is_taken = 0; alt_address = 0; is_link = 0;
  endtask

  task automatic apply_reset();
    RESET = 1'b0;
    set_idle();
    model_reset();
    #3;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic drive(input logic [31:0] fpc, input bit fadv, input bit idv, input bit br,
                       input bit tk, input bit lnk, input logic [31:0] idpc, input logic [31:0] alt);
    int fi, ri;
    bit fhit, rhit, used, ptk, mis;
    logic [31:0] corr;
    pred_t p;
    post_t q;
    @(negedge CLK);
    FetchPC = fpc; FetchAdvance = fadv; ID_PC = idpc; ID_Valid = idv;
    is_branch = br; is_taken = tk; is_link = lnk; alt_address = alt;
    #1;
    fi = int'(fpc[7:2]);
    fhit = m_valid[fi] && (m_tag[fi] == fpc[31:8]);
    p.taken  = fhit && (m_ctr[fi] >= 2);
    p.target = fhit ? m_tgt[fi] : fpc + 4;
    pred_q.push_back(p);

    used = m_pv && (m_ppc == idpc);
    ptk  = used && m_pt;
    if (br) mis = (ptk != tk) || (tk && (m_ptgt != alt));
    else    mis = ptk;
    if (!br)     corr = idpc + 4;
    else if (tk) corr = alt;
    else         corr = idpc + 8;

    ri = int'(idpc[7:2]);
    rhit = m_valid[ri] && (m_tag[ri] == idpc[31:8]);
    if (idv) begin
      if (br && rhit) begin
        m_ctr[ri] = tk ? ((m_ctr[ri] == 3) ? 3 : m_ctr[ri] + 1)
                       : ((m_ctr[ri] == 0) ? 0 : m_ctr[ri] - 1);
        if (tk) m_tgt[ri] = alt;
      end else if (br && tk) begin
        m_valid[ri] = 1; m_tag[ri] = idpc[31:8]; m_tgt[ri] = alt; m_ctr[ri] = 2;
      end else if (!br && rhit) begin
        m_valid[ri] = 0;
      end
      m_cpc = corr;
      if (br)        m_bc = m_bc + 1;
      if (mis)       m_mc = m_mc + 1;
      if (br && lnk) m_lc = m_lc + 1;
    end
    if (m_mis) m_pv = 0;
    else if (fadv) begin
      m_pv = 1; m_ppc = fpc; m_pt = p.taken; m_ptgt = p.target;
    end
    m_mis = idv && mis;
    q.mis = m_mis; q.cpc = m_cpc; q.bc = m_bc; q.mc = m_mc; q.lc = m_lc;
    post_q.push_back(q);
  endtask

  // Monitor: combinational prediction just before the edge, registered
  // outputs just after it.
  initial begin
    forever begin
      @(negedge CLK);
      #4;
      if (pred_q.size() > 0) begin
        pred_t p;
        p = pred_q.pop_front();
        chk("PredTaken", PredTaken, p.taken);
        chk("PredTarget", PredTarget, p.target);
      end
      @(posedge CLK);
      #1;
      if (post_q.size() > 0) begin
        post_t q;
        q = post_q.pop_front();
        chk("Mispredict", Mispredict, q.mis);
        chk("CorrectPC", CorrectPC, q.cpc);
        chk("BranchCount", BranchCount, q.bc);
        chk("MispredictCount", MispredictCount, q.mc);
        chk("LinkCount", LinkCount, q.lc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] PC_B = 32'h0040_0100;

  initial begin
    logic [31:0] fpc, idpc, alt;
    apply_reset();

    // Empty tables, counts zero
    drive(PC_B, 1, 0, 0, 0, 0, 0, 0);
    chk("reset PredTaken", PredTaken, 0);
    chk("reset PredTarget", PredTarget, 32'h0040_0104);
    chk("reset BranchCount", BranchCount, 0);

    // First resolve allocates and mispredicts
    drive(32'h0040_0104, 0, 1, 1, 1, 0, PC_B, 32'h0040_0200);
    @(posedge CLK); #2;
    chk("alloc Mispredict", Mispredict, 1);
    chk("alloc CorrectPC", CorrectPC, 32'h0040_0200);
    drive(PC_B, 0, 0, 0, 0, 0, 0, 0);
    chk("trained PredTaken", PredTaken, 1);
    chk("trained PredTarget", PredTarget, 32'h0040_0200);

    // Two not-taken resolves: 2 -> 1 -> 0
    drive(PC_B, 1, 0, 0, 0, 0, 0, 0);
    drive(32'h0040_0108, 0, 1, 1, 0, 0, PC_B, 32'h0040_0200);
    @(posedge CLK); #2;
    chk("nt1 Mispredict", Mispredict, 1);
    chk("nt1 CorrectPC", CorrectPC, 32'h0040_0108);
    drive(PC_B, 0, 0, 0, 0, 0, 0, 0);
    drive(PC_B, 1, 0, 0, 0, 0, 0, 0);
    drive(32'h0040_0108, 0, 1, 1, 0, 0, PC_B, 32'h0040_0200);
    @(posedge CLK); #2;
    chk("nt2 Mispredict", Mispredict, 0);
    drive(PC_B, 0, 0, 0, 0, 0, 0, 0);
    chk("ctr0 PredTaken", PredTaken, 0);

    // Retrain to taken, then alias with a non-branch
    drive(PC_B, 0, 1, 1, 1, 0, PC_B, 32'h0040_0200);
    drive(PC_B, 0, 1, 1, 1, 0, PC_B, 32'h0040_0200);
    drive(PC_B, 0, 0, 0, 0, 0, 0, 0);
    drive(PC_B, 1, 0, 0, 0, 0, 0, 0);
    drive(32'h0040_0104, 0, 1, 0, 0, 0, PC_B, 0);
    @(posedge CLK); #2;
    chk("alias Mispredict", Mispredict, 1);
    chk("alias CorrectPC", CorrectPC, 32'h0040_0104);
    drive(PC_B, 0, 0, 0, 0, 0, 0, 0);
    chk("alias PredTaken", PredTaken, 0);
    chk("alias PredTarget", PredTarget, 32'h0040_0104);

    // Changed target on a predicted-taken branch
    drive(PC_B, 0, 1, 1, 1, 0, PC_B, 32'h0040_0200);
    drive(PC_B, 0, 0, 0, 0, 0, 0, 0);
    drive(PC_B, 1, 0, 0, 0, 0, 0, 0);
    drive(32'h0040_0104, 0, 1, 1, 1, 0, PC_B, 32'h0040_0300);
    @(posedge CLK); #2;
    chk("retarget Mispredict", Mispredict, 1);
    chk("retarget CorrectPC", CorrectPC, 32'h0040_0300);
    drive(PC_B, 0, 0, 0, 0, 0, 0, 0);
    chk("retarget PredTaken", PredTaken, 1);
    chk("retarget PredTarget", PredTarget, 32'h0040_0300);

    // Statistics: 3 branches, one link, 2 mispredicts
    apply_reset();
    drive(32'h0040_0000, 0, 1, 1, 1, 0, PC_B, 32'h0040_0200);
    drive(32'h0040_0000, 0, 1, 1, 0, 1, 32'h0040_0300, 0);
    drive(32'h0040_0000, 0, 1, 1, 1, 0, PC_B, 32'h0040_0300);
    @(posedge CLK); #2;
    chk("stat BranchCount", BranchCount, 3);
    chk("stat MispredictCount", MispredictCount, 2);
    chk("stat LinkCount", LinkCount, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      fpc  = pool[$urandom_range(0, 7)];
      alt  = pool[$urandom_range(0, 7)];
      idpc = (m_pv && $urandom_range(0, 9) < 7) ? m_ppc : pool[$urandom_range(0, 7)];
      drive(fpc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, idpc, alt);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #2;
    chk("scoreboard drained", pred_q.size() + post_q.size(), 0);

    // Reset asserted during a Mispredict pulse
    apply_reset();
    drive(32'h0040_0104, 0, 1, 1, 1, 0, PC_B, 32'h0040_0200);
    @(posedge CLK); #2;
    chk("pre-reset Mispredict", Mispredict, 1);
    RESET = 1'b0;
    #1;
    chk("async reset Mispredict", Mispredict, 0);
    chk("async reset CorrectPC", CorrectPC, 0);
    FetchPC = PC_B;
    #1;
    chk("async reset PredTaken", PredTaken, 0);
    chk("async reset PredTarget", PredTarget, 32'h0040_0104);
    apply_reset();
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
